// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, RAM port owner encoding
// and default bus widths.
package cpu_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_t;

   localparam int AW_DEFAULT = 8;
   localparam int DW_DEFAULT = 16;
   localparam int CNT_W      = 3;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational winner, registered owner.
// On a tie the requester that is not the current owner wins.
module rr_arb2
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   reqF,
   input  logic   reqD,
   input  logic   advance,
   output owner_t winner,
   output owner_t owner
);
   owner_t ownerReg;

   always_comb begin
      winner = FETCH;
      if (reqF && reqD) begin
         if (ownerReg == FETCH) winner = DATA;
         else                   winner = FETCH;
      end else if (reqD) begin
         winner = DATA;
      end
   end

   // Reset owner to DATA so the very first tie goes to fetch.
   always_ff @(posedge clk) begin
      if (rst)                          ownerReg <= DATA;
      else if (advance && (reqF || reqD)) ownerReg <= winner;
   end

   assign owner = ownerReg;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between instruction fetch and the data path,
// sequencing one access at a time with req/gnt/rvalid per requester.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int AW     = AW_DEFAULT,
   parameter int DW     = DW_DEFAULT,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

   state_t             stateReg, stateNext;
   logic [CNT_W-1:0]   cntReg, cntNext;
   logic               weReg, weNext;
   owner_t             winner, owner;

   logic               memEnNext, memWeNext, busyNext;
   logic [AW-1:0]      memAddrNext;
   logic [DW-1:0]      memWdataNext, fRdataNext, dRdataNext;
   logic               fGntNext, dGntNext, fRvalidNext, dRvalidNext;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .reqF   (f_req),
      .reqD   (d_req),
      .advance(stateReg == IDLE),
      .winner (winner),
      .owner  (owner)
   );

   // Outputs are computed one cycle ahead so every port comes straight off a flop;
   // mem_addr/mem_wdata double as the request latch.
   always_comb begin
      stateNext    = stateReg;
      cntNext      = cntReg;
      weNext       = weReg;
      memEnNext    = 1'b0;
      memWeNext    = 1'b0;
      memAddrNext  = mem_addr;
      memWdataNext = mem_wdata;
      fGntNext     = 1'b0;
      dGntNext     = 1'b0;
      fRvalidNext  = 1'b0;
      dRvalidNext  = 1'b0;
      fRdataNext   = f_rdata;
      dRdataNext   = d_rdata;
      case (stateReg)
         IDLE: begin
            if (f_req || d_req) begin
               stateNext = ACCESS;
               memEnNext = 1'b1;
               if (winner == DATA) begin
                  weNext       = d_we;
                  memAddrNext  = d_addr;
                  memWdataNext = d_wdata;
                  dGntNext     = 1'b1;
               end else begin
                  weNext       = 1'b0;
                  memAddrNext  = f_addr;
                  memWdataNext = '0;
                  fGntNext     = 1'b1;
               end
               memWeNext = weNext;
            end
         end
         ACCESS: begin
            if (weReg) begin
               stateNext = IDLE;
            end else begin
               stateNext = WAIT;
               cntNext   = '0;
            end
         end
         WAIT: begin
            cntNext = cntReg + 1'b1;
            if (cntReg == LAST_CNT) begin
               stateNext = RESP;
               if (owner == DATA) begin
                  dRdataNext  = mem_rdata;
                  dRvalidNext = 1'b1;
               end else begin
                  fRdataNext  = mem_rdata;
                  fRvalidNext = 1'b1;
               end
            end
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      busyNext = (stateNext != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg  <= IDLE;
         cntReg    <= '0;
         weReg     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         f_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
         busy      <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         cntReg    <= cntNext;
         weReg     <= weNext;
         mem_en    <= memEnNext;
         mem_we    <= memWeNext;
         mem_addr  <= memAddrNext;
         mem_wdata <= memWdataNext;
         f_gnt     <= fGntNext;
         d_gnt     <= dGntNext;
         f_rvalid  <= fRvalidNext;
         d_rvalid  <= dRvalidNext;
         f_rdata   <= fRdataNext;
         d_rdata   <= dRdataNext;
         busy      <= busyNext;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (RD_LAT 1 and 3) share stimulus, each with its
// own behavioural RAM; expectations are hand-computed cycle numbers.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [7:0]  f_addr = 8'h00, d_addr = 8'h00;
   logic [15:0] d_wdata = 16'h0000;

   logic [1:0]  fGnt, fRvalid, dGnt, dRvalid, memEn, memWe, busy;
   logic [15:0] fRdata [2];
   logic [15:0] dRdata [2];
   logic [15:0] memWdata [2];
   logic [15:0] memRdata [2];
   logic [7:0]  memAddr [2];

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [15:0] ram [256];
      logic [15:0] pipe [LAT];

      mem_port_arbiter #(.AW(8), .DW(16), .RD_LAT(LAT)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .f_req    (f_req),
         .f_addr   (f_addr),
         .f_gnt    (fGnt[gi]),
         .f_rvalid (fRvalid[gi]),
         .f_rdata  (fRdata[gi]),
         .d_req    (d_req),
         .d_we     (d_we),
         .d_addr   (d_addr),
         .d_wdata  (d_wdata),
         .d_gnt    (dGnt[gi]),
         .d_rvalid (dRvalid[gi]),
         .d_rdata  (dRdata[gi]),
         .mem_en   (memEn[gi]),
         .mem_we   (memWe[gi]),
         .mem_addr (memAddr[gi]),
         .mem_wdata(memWdata[gi]),
         .mem_rdata(memRdata[gi]),
         .busy     (busy[gi])
      );

      // RAM model: data appears LAT cycles after the mem_en cycle, DEAD otherwise.
      always @(posedge clk) begin
         if (rst) ram[8'h10] <= 16'h4123;
         else if (memEn[gi] && memWe[gi]) ram[memAddr[gi]] <= memWdata[gi];
         pipe[0] <= (memEn[gi] && !memWe[gi]) ? ram[memAddr[gi]] : 16'hDEAD;
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign memRdata[gi] = pipe[LAT-1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic resetDut();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      // Reset held two cycles with a fetch request pending.
      rst = 1'b1;
      f_req = 1'b1;
      f_addr = 8'h10;
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            check("rst_busy", busy[i], 0);
            check("rst_mem_en", memEn[i], 0);
            check("rst_outs", |{fGnt[i], fRvalid[i], fRdata[i], dGnt[i], dRvalid[i],
                                dRdata[i], memWe[i], memAddr[i], memWdata[i]}, 0);
         end
         $display("reset cycle %0d: busy=%b mem_en=%b", c, busy, memEn);
      end
      rst = 1'b0;
      f_req = 1'b0;
      tick(2);

      // Single fetch read, RD_LAT = 1.
      f_req = 1'b1;
      f_addr = 8'h10;
      tick();
      check("f1_gnt", fGnt[0], 1);
      check("f1_mem_en", memEn[0], 1);
      check("f1_mem_addr", memAddr[0], 8'h10);
      check("f1_mem_we", memWe[0], 0);
      check("f1_dgnt", dGnt[0], 0);
      f_req = 1'b0;
      tick();
      check("f1_rvalid_c2", fRvalid[0], 0);
      check("f1_mem_en_c2", memEn[0], 0);
      tick();
      check("f1_rvalid_c3", fRvalid[0], 1);
      check("f1_rdata", fRdata[0], 16'h4123);
      tick();
      check("f1_idle_c4", busy[0], 0);
      $display("fetch read: f_rdata=%h", fRdata[0]);
      tick(4);

      // Data write then readback.
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF;
      tick();
      check("w_dgnt", dGnt[0], 1);
      check("w_mem_en", memEn[0], 1);
      check("w_mem_we", memWe[0], 1);
      check("w_mem_addr", memAddr[0], 8'h20);
      check("w_mem_wdata", memWdata[0], 16'hBEEF);
      check("w_rvalid", dRvalid[0], 0);
      d_req = 1'b0;
      tick();
      check("w_idle_c2", busy[0], 0);
      check("w_rvalid_c2", dRvalid[0], 0);
      $display("data write: addr=20 data=BEEF");
      tick(2);
      d_req = 1'b1; d_we = 1'b0;
      tick();
      check("rb_dgnt", dGnt[0], 1);
      d_req = 1'b0;
      tick(2);
      check("rb_rvalid", dRvalid[0], 1);
      check("rb_rdata", dRdata[0], 16'hBEEF);
      check("rb_no_frvalid", fRvalid[0], 0);
      $display("readback: d_rdata=%h", dRdata[0]);
      tick(6);

      // Tie after reset, then continuous dual requests alternate F, D, F, D.
      resetDut();
      f_req = 1'b1; f_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      for (int c = 1; c <= 24; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            int p, ph, k;
            p  = (i == 0) ? 4 : 6;
            ph = c % p;
            k  = c / p;
            check("tie_fgnt", fGnt[i], 32'((ph == 1) && (k % 2 == 0)));
            check("tie_dgnt", dGnt[i], 32'((ph == 1) && (k % 2 == 1)));
            check("tie_frvalid", fRvalid[i], 32'((ph == p - 1) && (k % 2 == 0)));
            check("tie_drvalid", dRvalid[i], 32'((ph == p - 1) && (k % 2 == 1)));
            if (fRvalid[i]) check("tie_frdata", fRdata[i], 16'h4123);
            if (dRvalid[i]) check("tie_drdata", dRdata[i], 16'hBEEF);
         end
         $display("tie cycle %0d: f_gnt=%b d_gnt=%b f_rvalid=%b d_rvalid=%b",
                  c, fGnt, dGnt, fRvalid, dRvalid);
      end
      f_req = 1'b0;
      d_req = 1'b0;
      tick(8);

      // RD_LAT = 3 data read.
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check("l3_busy", busy[1], 32'(c <= 5));
         check("l3_dgnt", dGnt[1], 32'(c == 1));
         check("l3_drvalid", dRvalid[1], 32'(c == 5));
         if (c == 5) check("l3_drdata", dRdata[1], 16'hBEEF);
         d_req = 1'b0;
         $display("lat3 read cycle %0d: busy=%b d_gnt=%b d_rvalid=%b", c, busy[1], dGnt[1], dRvalid[1]);
      end
      tick(2);

      // Reset during WAIT abandons the read; a later fetch completes normally.
      f_req = 1'b1; f_addr = 8'h10;
      tick();
      check("ab_fgnt0", fGnt[0], 1);
      check("ab_fgnt1", fGnt[1], 1);
      f_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) check("ab_idle", busy[i], 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            check("ab_no_rvalid", fRvalid[i], 0);
            check("ab_no_mem_en", memEn[i], 0);
         end
      end
      $display("abort: f_rvalid=%b mem_en=%b busy=%b", fRvalid, memEn, busy);
      f_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            int lat;
            lat = (i == 0) ? 1 : 3;
            check("post_fgnt", fGnt[i], 32'(c == 1));
            check("post_frvalid", fRvalid[i], 32'(c == 2 + lat));
            if (c == 2 + lat) check("post_frdata", fRdata[i], 16'h4123);
         end
         f_req = 1'b0;
      end
      $display("post-abort fetch: f_rdata=%h/%h", fRdata[0], fRdata[1]);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

   // Pulse exclusivity, checked every cycle on both instances.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (fGnt[i] && dGnt[i]) check("excl_gnt", 2'b11, 2'b01);
            if (fRvalid[i] && dRvalid[i]) check("excl_rvalid", 2'b11, 2'b01);
         end
      end
   end
endmodule
